vc_buffer_bank: RTL and testbench

VC_BUFFER_BANK -- requirements
Module: vc_buffer_bank

---
 rtl/vc_buffer_bank_pkg.sv | 15 +
 rtl/vc_fifo_ctrl.sv | 77 +++++++
 rtl/vc_buffer_bank.sv | 159 +++++++++++++++
 tb/tb_vc_buffer_bank.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/vc_buffer_bank_pkg.sv
// Shared NoC parameters and types for the VC buffer bank.
// Provides flit_t, VC_NUM, VC_DEPTH and the VC selector type vc_sel_t.
package noc_params;

    localparam int FLIT_W   = 16;
    localparam int VC_NUM   = 2;
    localparam int VC_DEPTH = 4;

    typedef logic [FLIT_W-1:0] flit_t;

    localparam int VC_SEL_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    typedef logic [VC_SEL_W-1:0] vc_sel_t;

endpackage

// File: rtl/vc_fifo_ctrl.sv
// Per-VC FIFO control: pointers, occupancy, full/empty and accept logic.
// Ports: clk, rst_n (sync, active-low), wr_req_i/rd_req_i requests,
//   wr_ok_o/rd_ok_o accepts, wr_ptr_o/rd_ptr_o, count_o, full_o, empty_o.
// Macro VC_BUFFER_CHECK_EN gates writes into a full VC.
module vc_fifo_ctrl #(
    parameter int  DEPTH = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_req_i,
    input  logic          rd_req_i,
    output logic          wr_ok_o,
    output logic          rd_ok_o,
    output logic [PW-1:0] wr_ptr_o,
    output logic [PW-1:0] rd_ptr_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        empty_o = (count_q == '0);
        full_o  = (count_q == CW'(DEPTH));
        // Reads never bypass a same-edge write: an empty VC stays unreadable.
        rd_ok_o = rd_req_i && !empty_o;
`ifdef VC_BUFFER_CHECK_EN
        // A full VC may still take a write if a read frees a slot this edge.
        wr_ok_o = wr_req_i && (!full_o || rd_ok_o);
`else
        wr_ok_o = wr_req_i;
`endif
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok_o) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (rd_ok_o) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({wr_ok_o, rd_ok_o})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr_o = wr_ptr_q;
    assign rd_ptr_o = rd_ptr_q;
    assign count_o  = count_q;

endmodule

// File: rtl/vc_buffer_bank.sv
// Bank of NUM_VC independent flit FIFOs sharing one write and one read port.
// Ports: clk, rst_n (sync, active-low); data_i/write_i/write_vc_i write side;
//   read_i/read_vc_i read side; data_o/valid_o registered read data;
//   peek_o head flits; is_full_o/is_empty_o/count_o status; credit_o pulses;
//   err_overflow_o/err_underflow_o sticky flags (macro VC_BUFFER_CHECK_EN).
module vc_buffer_bank
    import noc_params::*;
#(
    parameter int  NUM_VC = VC_NUM,
    parameter int  DEPTH  = VC_DEPTH,
    localparam int VCW    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int CW     = $clog2(DEPTH + 1),
    localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  flit_t                      data_i,
    input  logic                       write_i,
    input  logic [VCW-1:0]             write_vc_i,
    input  logic                       read_i,
    input  logic [VCW-1:0]             read_vc_i,
    output flit_t                      data_o,
    output logic                       valid_o,
    output flit_t [NUM_VC-1:0]         peek_o,
    output logic [NUM_VC-1:0]          is_full_o,
    output logic [NUM_VC-1:0]          is_empty_o,
    output logic [NUM_VC-1:0][CW-1:0]  count_o,
    output logic [NUM_VC-1:0]          credit_o,
    output logic                       err_overflow_o,
    output logic                       err_underflow_o
);

    logic [NUM_VC-1:0]         wr_req;
    logic [NUM_VC-1:0]         rd_req;
    logic [NUM_VC-1:0]         wr_ok;
    logic [NUM_VC-1:0]         rd_ok;
    logic [NUM_VC-1:0][PW-1:0] wr_ptr;
    logic [NUM_VC-1:0][PW-1:0] rd_ptr;

    flit_t                     mem_q [NUM_VC][DEPTH];

    flit_t                     data_q, data_d;
    logic                      valid_q, valid_d;
    logic [NUM_VC-1:0]         credit_q, credit_d;

    // Out-of-range indices match no VC, so they address nothing.
    always_comb begin
        wr_req = '0;
        rd_req = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            wr_req[v] = write_i && (32'(write_vc_i) == v);
            rd_req[v] = read_i && (32'(read_vc_i) == v);
        end
    end

    for (genvar g = 0; g < NUM_VC; g++) begin : g_vc
        vc_fifo_ctrl #(
            .DEPTH (DEPTH)
        ) u_ctrl (
            .clk      (clk),
            .rst_n    (rst_n),
            .wr_req_i (wr_req[g]),
            .rd_req_i (rd_req[g]),
            .wr_ok_o  (wr_ok[g]),
            .rd_ok_o  (rd_ok[g]),
            .wr_ptr_o (wr_ptr[g]),
            .rd_ptr_o (rd_ptr[g]),
            .count_o  (count_o[g]),
            .full_o   (is_full_o[g]),
            .empty_o  (is_empty_o[g])
        );
    end

    // Storage is not reset; writes during reset are ignored.
    always_ff @(posedge clk) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (rst_n && wr_ok[v]) begin
                mem_q[v][wr_ptr[v]] <= data_i;
            end
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            peek_o[v] = mem_q[v][rd_ptr[v]];
        end
    end

    // At most one VC reads per edge, so the loop selects a single head.
    always_comb begin
        data_d   = data_q;
        valid_d  = 1'b0;
        credit_d = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (rd_ok[v]) begin
                data_d      = peek_o[v];
                valid_d     = 1'b1;
                credit_d[v] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q   <= '0;
            valid_q  <= 1'b0;
            credit_q <= '0;
        end else begin
            data_q   <= data_d;
            valid_q  <= valid_d;
            credit_q <= credit_d;
        end
    end

    assign data_o   = data_q;
    assign valid_o  = valid_q;
    assign credit_o = credit_q;

`ifdef VC_BUFFER_CHECK_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        for (int v = 0; v < NUM_VC; v++) begin
            if (wr_req[v] && !wr_ok[v]) begin
                ovf_d = 1'b1;
            end
            if (rd_req[v] && !rd_ok[v]) begin
                udf_d = 1'b1;
            end
        end
        if (write_i && (32'(write_vc_i) >= NUM_VC)) begin
            ovf_d = 1'b1;
        end
        if (read_i && (32'(read_vc_i) >= NUM_VC)) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign err_overflow_o  = ovf_q;
    assign err_underflow_o = udf_q;
`else
    assign err_overflow_o  = 1'b0;
    assign err_underflow_o = 1'b0;
`endif

endmodule

// File: tb/tb_vc_buffer_bank.sv
// Self-checking bench for vc_buffer_bank (NUM_VC=2, DEPTH=4).
// Queue-based reference model; directed scenarios then random traffic.
module tb_vc_buffer_bank;
    import noc_params::*;

    localparam int NV = 2;
    localparam int DP = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    flit_t                data_i;
    logic                 write_i;
    logic [0:0]           write_vc_i;
    logic                 read_i;
    logic [0:0]           read_vc_i;
    flit_t                data_o;
    logic                 valid_o;
    flit_t [NV-1:0]       peek_o;
    logic [NV-1:0]        is_full_o;
    logic [NV-1:0]        is_empty_o;
    logic [NV-1:0][2:0]   count_o;
    logic [NV-1:0]        credit_o;
    logic                 err_overflow_o;
    logic                 err_underflow_o;

    int total = 0;
    int bad   = 0;

    flit_t     q [NV][$];
    flit_t     exp_data;
    logic      exp_valid;
    logic [1:0] exp_credit;
    logic      exp_ovf;
    logic      exp_udf;

    always #5 clk = ~clk;

    vc_buffer_bank #(
        .NUM_VC (NV),
        .DEPTH  (DP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .data_i          (data_i),
        .write_i         (write_i),
        .write_vc_i      (write_vc_i),
        .read_i          (read_i),
        .read_vc_i       (read_vc_i),
        .data_o          (data_o),
        .valid_o         (valid_o),
        .peek_o          (peek_o),
        .is_full_o       (is_full_o),
        .is_empty_o      (is_empty_o),
        .count_o         (count_o),
        .credit_o        (credit_o),
        .err_overflow_o  (err_overflow_o),
        .err_underflow_o (err_underflow_o)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("valid", 32'(valid_o), 32'(exp_valid));
        chk("data", 32'(data_o), 32'(exp_data));
        chk("credit", 32'(credit_o), 32'(exp_credit));
        chk("ovf", 32'(err_overflow_o), 32'(exp_ovf));
        chk("udf", 32'(err_underflow_o), 32'(exp_udf));
        for (int v = 0; v < NV; v++) begin
            chk($sformatf("count%0d", v), 32'(count_o[v]), q[v].size());
            chk($sformatf("full%0d", v), 32'(is_full_o[v]),
                32'(q[v].size() == DP));
            chk($sformatf("empty%0d", v), 32'(is_empty_o[v]),
                32'(q[v].size() == 0));
            if (q[v].size() > 0) begin
                chk($sformatf("peek%0d", v), 32'(peek_o[v]), 32'(q[v][0]));
            end
        end
    endtask

    // One clock edge with the given request; model follows the FIFO rules.
    task automatic step(input bit rst, input bit w, input int wv,
                        input bit r, input int rv, input flit_t d);
        bit rok;
        bit wok;
        rst_n      = !rst;
        write_i    = w;
        write_vc_i = 1'(wv);
        read_i     = r;
        read_vc_i  = 1'(rv);
        data_i     = d;
        @(posedge clk);
        if (rst) begin
            for (int v = 0; v < NV; v++) q[v].delete();
            exp_data   = '0;
            exp_valid  = 1'b0;
            exp_credit = '0;
            exp_ovf    = 1'b0;
            exp_udf    = 1'b0;
        end else begin
            rok = r && (q[rv].size() > 0);
            wok = w && ((q[wv].size() < DP) || (rok && rv == wv));
            if (r && !rok) exp_udf = 1'b1;
            if (w && !wok) exp_ovf = 1'b1;
`ifndef VC_BUFFER_CHECK_EN
            exp_udf = 1'b0;
            exp_ovf = 1'b0;
`endif
            exp_valid  = rok;
            exp_credit = '0;
            if (rok) begin
                exp_data = q[rv].pop_front();
                exp_credit[rv] = 1'b1;
            end
            if (wok) q[wv].push_back(d);
        end
        #1;
        check_all();
    endtask

    initial begin
        flit_t fl;
        bit    w;
        bit    r;
        int    wv;
        int    rv;
        exp_data   = '0;
        exp_valid  = 1'b0;
        exp_credit = '0;
        exp_ovf    = 1'b0;
        exp_udf    = 1'b0;

        // Reset with junk requests pending.
        step(1, 1, 0, 1, 0, 16'hdead);
        step(1, 1, 1, 1, 1, 16'hbeef);

        // Fill VC0 then drain it.
        step(0, 1, 0, 0, 0, 16'h00a0);
        step(0, 1, 0, 0, 0, 16'h00b0);
        step(0, 1, 0, 0, 0, 16'h00c0);
        step(0, 1, 0, 0, 0, 16'h00d0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 16'h0);
        step(0, 0, 0, 0, 0, 16'h0);

        // Full VC0 with same-edge write and read, then drain across wrap.
        step(0, 1, 0, 0, 0, 16'h10a0);
        step(0, 1, 0, 0, 0, 16'h10b0);
        step(0, 1, 0, 0, 0, 16'h10c0);
        step(0, 1, 0, 0, 0, 16'h10d0);
        step(0, 1, 0, 1, 0, 16'h10e0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 16'h0);

        // Write VC1 while reading VC0.
        step(0, 1, 0, 0, 0, 16'h20a0);
        step(0, 1, 0, 0, 0, 16'h20b0);
        step(0, 1, 1, 1, 0, 16'h2111);
        step(0, 0, 0, 1, 0, 16'h0);
        step(0, 0, 0, 1, 1, 16'h0);

`ifdef VC_BUFFER_CHECK_EN
        // Overflow of full VC0 and underflow of empty VC1.
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 16'h3000 + 16'(i));
        step(0, 1, 0, 0, 0, 16'h3bad);
        step(0, 0, 0, 1, 1, 16'h0);
        step(0, 0, 0, 0, 0, 16'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 16'h0);
`endif

        // Reset mid-operation with three flits buffered.
        step(0, 1, 0, 0, 0, 16'h40a0);
        step(0, 1, 0, 0, 0, 16'h40b0);
        step(0, 1, 0, 1, 0, 16'h40c0);
        step(0, 1, 0, 0, 0, 16'h40d0);
        step(1, 1, 1, 1, 0, 16'h4fff);
        chk("rst_empty", 32'(is_empty_o), 32'h3);

        // Empty VC1: same-edge write and read does not bypass.
        step(0, 1, 1, 1, 1, 16'h5111);
        step(0, 0, 0, 1, 1, 16'h0);

        // Random legal traffic (any traffic when checking is enabled).
        for (int i = 0; i < 600; i++) begin
            w  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            wv = $urandom_range(0, NV - 1);
            rv = $urandom_range(0, NV - 1);
            fl = flit_t'($urandom);
`ifndef VC_BUFFER_CHECK_EN
            if (w && q[wv].size() == DP &&
                !(r && rv == wv)) begin
                w = 1'b0;
            end
`endif
            step(($urandom_range(0, 99) == 0), w, wv, r, rv, fl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
